// File: rtl/result_serializer.sv
// result_serializer: captures four multiplier results and streams them out MSB-first as bytes over valid/ready.
module result_serializer #(
  parameter int RES_W   = 16,
  parameter int BYTE_W  = 8,
  parameter int NUM_RES = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RES_W-1:0]  result1,
  input  logic [RES_W-1:0]  result2,
  input  logic [RES_W-1:0]  result3,
  input  logic [RES_W-1:0]  result4,
  input  logic              multiplication_done,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic [CNT_W-1:0]  frame_count
);
  localparam int BUF_W = NUM_RES * RES_W;
  localparam int NB    = BUF_W / BYTE_W;
  localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_d;
  logic [BUF_W-1:0]  sbuf, sbuf_d;
  logic [BC_W-1:0]   cnt, cnt_d;
  logic [CNT_W-1:0]  fc_d;
  logic              done_q, ovr_d, rise, xfer, last_xfer, adv, load;

  always_comb begin
    rise      = multiplication_done & ~done_q;
    out_valid = state == SEND;
    busy      = out_valid;
    out_last  = out_valid && cnt == BC_W'(NB - 1);
    out_data  = sbuf[BUF_W-1 -: BYTE_W];
    xfer      = out_valid & out_ready;
    last_xfer = xfer & out_last;
    adv       = xfer & ~out_last;
    // A new set is accepted only when idle or exactly as the last byte leaves.
    load      = rise & (~out_valid | last_xfer);
    state_d   = load ? SEND : last_xfer ? IDLE : state;
    sbuf_d    = load ? BUF_W'({result1, result2, result3, result4}) : adv ? sbuf << BYTE_W : sbuf;
    cnt_d     = load ? '0 : adv ? cnt + 1'b1 : cnt;
    fc_d      = frame_count + CNT_W'(last_xfer);
    ovr_d     = (rise & ~load) | (overrun & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sbuf        <= '0;
      cnt         <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_d;
      sbuf        <= sbuf_d;
      cnt         <= cnt_d;
      frame_count <= fc_d;
      overrun     <= ovr_d;
      done_q      <= multiplication_done;
    end
  end
endmodule
